dvp_frame_tx: RTL and testbench
===============================

DVP_FRAME_TX -- requirements
Module: dvp_frame_tx

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACT, 320, active pixels per line.
REQ-002 Parameters SHALL include V_ACT, 240, active lines per frame.
REQ-003 Parameters SHALL include H_BLANK, 144, HREF-low cycles after each line's active bytes.
REQ-004 Parameters SHALL include VS_LINES, 3, line periods with VSYNC high.
REQ-005 Parameters SHALL include V_BP, 17, blank line periods between VSYNC and first active line.
REQ-006 Parameters SHALL include V_FP, 10, blank line periods after last active line.
REQ-007 Line period SHALL be LP = 2*H_ACT + H_BLANK cycles everywhere.
REQ-008 Port iClk, input, 1: single clock; all logic on its rising edge.
REQ-009 Port iRst, input, 1: reset, synchronous, active-high.
REQ-010 Port iStart, input, 1: one-cycle pulse that starts frame output from IDLE.
REQ-011 Port iContinuous, input, 1: when high, the next frame follows the current one without returning to IDLE.
REQ-012 Port oRdEn, output, 1: frame-buffer read strobe.
REQ-013 Port oRdAddr, output, 17: frame-buffer pixel address.
REQ-014 Port iRdData, input, 16: RGB565 pixel, valid exactly 1 cycle after oRdEn.
REQ-015 Port oVsync, output, 1: DVP VSYNC, active high.
REQ-016 Port oHref, output, 1: DVP HREF; high only during active bytes.
REQ-017 Port oData, output, 8: DVP byte; 0 whenever oHref is 0.
REQ-018 Port oBusy, output, 1: high in every state except IDLE.
REQ-019 Port oFrameDone, output, 1: one-cycle pulse at end of each frame.

Function
REQ-020 The block SHALL be the transmitter counterpart of the camera-to-RAM receiver: it reads a stored frame and emits a DVP byte stream accepted by that receiver unchanged.
REQ-021 FSM states SHALL be IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
REQ-022 IDLE->VSYNC SHALL occur on iStart=1; iStart in any other state SHALL be ignored.
REQ-023 VSYNC SHALL last VS_LINES*LP cycles with oVsync=1, then go to VBP.
REQ-024 VBP SHALL last V_BP*LP cycles, then go to ACTIVE.
REQ-025 ACTIVE SHALL last 2*H_ACT cycles with oHref=1.
REQ-026 Each ACTIVE period SHALL be followed by HBLANK for H_BLANK cycles.
REQ-027 After HBLANK, the FSM SHALL return to ACTIVE, or go to VFP after line V_ACT-1.
REQ-028 VFP SHALL last V_FP*LP cycles.
REQ-029 On the last VFP cycle, oFrameDone SHALL be 1.
REQ-030 On leaving VFP, the next state SHALL be VSYNC if iContinuous=1 in that cycle, else IDLE.
REQ-031 Byte order SHALL be pixel k of line y output as two bytes: byte 2k = pix[15:8], byte 2k+1 = pix[7:0], where pix is the content of address y*H_ACT + k.
REQ-032 Pixel reads SHALL be issued so the high byte of pixel k appears on oData exactly 2 cycles after its oRdEn cycle.
REQ-033 The read for pixel 0 of a line SHALL therefore be issued 2 cycles before the line's first ACTIVE cycle (inside VBP or HBLANK).
REQ-034 Reads for subsequent pixels SHALL be issued every 2 cycles.
REQ-035 oRdEn SHALL pulse exactly H_ACT times per line and H_ACT*V_ACT times per frame.
REQ-036 oRdEn SHALL never pulse outside a frame.
REQ-037 oRdAddr SHALL start at 0 each frame and increment by 1 per read, reaching H_ACT*V_ACT-1 (76799 at default parameters).
REQ-038 oRdAddr SHALL be reset to 0 at VSYNC entry, with no carry between frames.
REQ-039 oRdAddr SHALL hold its value when oRdEn=0.
REQ-040 The read pixel SHALL be latched so that iRdData changing after its valid cycle does not corrupt the low byte.
REQ-041 oVsync, oHref, oData, oRdEn and oFrameDone SHALL all be registered outputs.
REQ-042 Counters SHALL be sized from the parameters, and no counter SHALL overflow at the default parameters.

Reset
REQ-043 On the iRst=1 edge, the FSM SHALL go to IDLE and all counters SHALL clear, including mid-frame or mid-line.
REQ-044 During reset, oVsync, oHref, oRdEn, oBusy and oFrameDone SHALL be 0, and oData and oRdAddr SHALL be 0.
REQ-045 If iRst and iStart are both 1 in the same cycle, reset SHALL win and the FSM SHALL stay in IDLE.
REQ-046 The first frame after reset SHALL begin at oRdAddr 0.

Verification (H_ACT=4, V_ACT=2, H_BLANK=3, VS_LINES=1, V_BP=1, V_FP=1, so LP=11)
REQ-047 Single frame: iStart pulse with iRdData = {addr, ~addr} pattern -> oVsync high for 11 cycles; 2 HREF bursts of 8 bytes; oData high byte/low byte per REQ-031; oRdAddr 0..7; one oFrameDone pulse; oBusy falls in the following cycle.
REQ-048 Read latency: check every oRdEn cycle t -> the high byte of that address appears on oData at t+2 with oHref=1.
REQ-049 Continuous: iContinuous=1 across 3 frames -> VSYNC restarts the cycle after each oFrameDone; oRdAddr returns to 0; 24 total reads.
REQ-050 Reset mid-line: assert iRst during byte 3 of line 1 -> outputs 0 on the next edge; a new iStart then produces a frame identical to REQ-047.
REQ-051 Ignored start: iStart pulses during ACTIVE and VFP -> frame timing unchanged; no second frame when iContinuous=0.
REQ-052 Loopback: drive the existing camera-to-RAM receiver from oVsync/oHref/oData -> received RAM contents equal the source frame word-for-word.

Source files
------------

// File: rtl/dvp_frame_tx.sv
// DVP frame transmitter: reads an RGB565 frame from a buffer and emits the
// VSYNC/HREF/byte stream a DVP camera would produce. The whole frame is a
// whole number of line periods (LP = 2*H_ACT + H_BLANK). The horizontal
// counter runs free across every non-IDLE state, and the line counter counts
// line periods within the current state.
// Parameter assumptions: H_ACT >= 2, H_BLANK >= 2, all line counts >= 1.
module dvp_frame_tx #(
   parameter int unsigned H_ACT    = 320,
   parameter int unsigned V_ACT    = 240,
   parameter int unsigned H_BLANK  = 144,
   parameter int unsigned VS_LINES = 3,
   parameter int unsigned V_BP     = 17,
   parameter int unsigned V_FP     = 10
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iStart,
   input  logic        iContinuous,
   output logic        oRdEn,
   output logic [16:0] oRdAddr,
   input  logic [15:0] iRdData,
   output logic        oVsync,
   output logic        oHref,
   output logic [7:0]  oData,
   output logic        oBusy,
   output logic        oFrameDone
);

   localparam int unsigned LP      = 2 * H_ACT + H_BLANK;
   localparam int unsigned ACT_LEN = 2 * H_ACT;
   localparam int unsigned RD_LIM  = 2 * H_ACT - 3;
   localparam int unsigned HCNT_W  = $clog2(LP);
   localparam int unsigned VCNT_W  = $clog2(VS_LINES + V_BP + V_ACT + V_FP);
   localparam int unsigned ADDR_W  = 17;

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP
   } state_t;

   state_t              r_state;
   logic [HCNT_W-1:0]   r_hcnt;
   logic [VCNT_W-1:0]   r_vcnt;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_first;
   logic                r_rden;
   logic                r_vsync;
   logic                r_href;
   logic                r_done;
   logic                r_rd_d1;
   logic                r_rd_d2;
   logic [15:0]         r_pix;
   logic [7:0]          r_data;

   logic                w_hend;
   logic                w_pre_line;
   logic                w_rd_next;

   // Last cycle of the current line period.
   assign w_hend = (r_hcnt == HCNT_W'(LP - 1));

   // The line period that follows the current one carries active pixels.
   assign w_pre_line = ((r_state == S_VBP) && (r_vcnt == VCNT_W'(V_BP - 1))) ||
                       (((r_state == S_ACTIVE) || (r_state == S_HBLANK)) &&
                        (r_vcnt != VCNT_W'(V_ACT - 1)));

   // Next cycle is a read: pixel 0 two cycles before the line, pixel 1 on the
   // first active cycle, then every second cycle so each high byte lands two
   // cycles after its strobe.
   assign w_rd_next = (w_pre_line && ((r_hcnt == HCNT_W'(LP - 3)) || w_hend)) ||
                      ((r_state == S_ACTIVE) && r_hcnt[0] && (r_hcnt < HCNT_W'(RD_LIM)));

   // Frame sequencing, line/cycle counters, read strobe and address.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state <= S_IDLE;
         r_hcnt  <= '0;
         r_vcnt  <= '0;
         r_addr  <= '0;
         r_first <= 1'b0;
         r_rden  <= 1'b0;
         r_vsync <= 1'b0;
         r_href  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_rden <= w_rd_next;
         if (w_rd_next) begin
            if (r_first) r_first <= 1'b0;
            else         r_addr  <= r_addr + ADDR_W'(1);
         end
         if (r_state != S_IDLE) r_hcnt <= w_hend ? '0 : r_hcnt + HCNT_W'(1);

         case (r_state)
            S_IDLE: begin
               if (iStart) begin
                  r_state <= S_VSYNC;
                  r_vsync <= 1'b1;
                  r_hcnt  <= '0;
                  r_vcnt  <= '0;
                  r_addr  <= '0;
                  r_first <= 1'b1;
               end
            end
            S_VSYNC: begin
               if (w_hend) begin
                  if (r_vcnt == VCNT_W'(VS_LINES - 1)) begin
                     r_state <= S_VBP;
                     r_vsync <= 1'b0;
                     r_vcnt  <= '0;
                  end else begin
                     r_vcnt <= r_vcnt + VCNT_W'(1);
                  end
               end
            end
            S_VBP: begin
               if (w_hend) begin
                  if (r_vcnt == VCNT_W'(V_BP - 1)) begin
                     r_state <= S_ACTIVE;
                     r_href  <= 1'b1;
                     r_vcnt  <= '0;
                  end else begin
                     r_vcnt <= r_vcnt + VCNT_W'(1);
                  end
               end
            end
            S_ACTIVE: begin
               if (r_hcnt == HCNT_W'(ACT_LEN - 1)) begin
                  r_state <= S_HBLANK;
                  r_href  <= 1'b0;
               end
            end
            S_HBLANK: begin
               if (w_hend) begin
                  if (r_vcnt == VCNT_W'(V_ACT - 1)) begin
                     r_state <= S_VFP;
                     r_vcnt  <= '0;
                  end else begin
                     r_state <= S_ACTIVE;
                     r_href  <= 1'b1;
                     r_vcnt  <= r_vcnt + VCNT_W'(1);
                  end
               end
            end
            S_VFP: begin
               if ((r_vcnt == VCNT_W'(V_FP - 1)) && (r_hcnt == HCNT_W'(LP - 2)))
                  r_done <= 1'b1;
               if (w_hend) begin
                  if (r_vcnt == VCNT_W'(V_FP - 1)) begin
                     r_vcnt <= '0;
                     if (iContinuous) begin
                        r_state <= S_VSYNC;
                        r_vsync <= 1'b1;
                        r_addr  <= '0;
                        r_first <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_vcnt <= r_vcnt + VCNT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pixel capture and byte serialiser: high byte straight from the read
   // data, low byte from the latched copy one cycle later.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_rd_d1 <= 1'b0;
         r_rd_d2 <= 1'b0;
         r_pix   <= '0;
         r_data  <= '0;
      end else begin
         r_rd_d1 <= r_rden;
         r_rd_d2 <= r_rd_d1;
         if (r_rd_d1) begin
            r_pix  <= iRdData;
            r_data <= iRdData[15:8];
         end else if (r_rd_d2) begin
            r_data <= r_pix[7:0];
         end else begin
            r_data <= '0;
         end
      end
   end

   assign oRdEn      = r_rden;
   assign oRdAddr    = r_addr;
   assign oVsync     = r_vsync;
   assign oHref      = r_href;
   assign oData      = r_data;
   assign oFrameDone = r_done;
   assign oBusy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Bench for dvp_frame_tx at a reduced frame geometry (LP = 11, 55-cycle frame).
// Every cycle of a frame is compared against a reference timeline built from
// the frame geometry; the frame buffer is a 1-cycle-latency model that drives
// junk whenever no read is pending.
module tb_dvp_frame_tx;

   localparam int H_ACT = 4;
   localparam int V_ACT = 2;
   localparam int H_BL  = 3;
   localparam int VS    = 1;
   localparam int VBP   = 1;
   localparam int VFP   = 1;
   localparam int LP    = 2 * H_ACT + H_BL;
   localparam int FRM   = (VS + VBP + V_ACT + VFP) * LP;
   localparam int NPIX  = H_ACT * V_ACT;

   logic        clk = 1'b0;
   logic        iRst;
   logic        iStart;
   logic        iContinuous;
   logic        oRdEn;
   logic [16:0] oRdAddr;
   logic [15:0] iRdData;
   logic        oVsync;
   logic        oHref;
   logic [7:0]  oData;
   logic        oBusy;
   logic        oFrameDone;
   logic [29:0] obs;

   int n_tests = 0;
   int n_fail  = 0;
   int rd_a, rd_b, rd_c, rd_tot;

   always #5 clk = ~clk;

   dvp_frame_tx #(
      .H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BL),
      .VS_LINES(VS), .V_BP(VBP), .V_FP(VFP)
   ) dut (
      .iClk(clk), .iRst(iRst), .iStart(iStart), .iContinuous(iContinuous),
      .oRdEn(oRdEn), .oRdAddr(oRdAddr), .iRdData(iRdData),
      .oVsync(oVsync), .oHref(oHref), .oData(oData),
      .oBusy(oBusy), .oFrameDone(oFrameDone)
   );

   assign obs = {oBusy, oFrameDone, oVsync, oHref, oRdEn, oRdAddr, oData};

   function automatic logic [15:0] pix(input int a);
      logic [7:0] b;
      b = 8'(a);
      return {b, ~b};
   endfunction

   // Frame buffer: data valid exactly one cycle after the strobe, junk otherwise.
   always @(posedge clk) iRdData <= oRdEn ? pix(int'(oRdAddr)) : 16'hA5A5;

   // Reference outputs for cycle n of a frame (n = 0 is the first VSYNC cycle).
   function automatic logic [29:0] exp_vec(input int n);
      int ln, h, y, nrd, t;
      logic vs, hr, rd, dn;
      logic [7:0] d;
      logic [15:0] p;
      ln = n / LP;
      h  = n % LP;
      y  = ln - VS - VBP;
      vs = (ln < VS);
      hr = (y >= 0) && (y < V_ACT) && (h < 2 * H_ACT);
      d  = 8'h00;
      if (hr) begin
         p = pix(y * H_ACT + h / 2);
         d = (h % 2 == 0) ? p[15:8] : p[7:0];
      end
      nrd = 0;
      rd  = 1'b0;
      for (int yy = 0; yy < V_ACT; yy++)
         for (int kk = 0; kk < H_ACT; kk++) begin
            t = (VS + VBP + yy) * LP + 2 * kk - 2;
            if (t <= n) nrd++;
            if (t == n) rd = 1'b1;
         end
      dn = (n == FRM - 1);
      return {1'b1, dn, vs, hr, rd, 17'((nrd > 0) ? nrd - 1 : 0), d};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Step one frame cycle by cycle, optionally pulsing iStart, dropping
   // iContinuous or asserting reset after a given cycle.
   task automatic run_frame(input string name, input int pulse_a, input int pulse_b,
                            input int drop_n, input int rst_n, output int reads);
      reads = 0;
      for (int n = 0; n < FRM; n++) begin
         @(negedge clk);
         check_eq($sformatf("%s.n%0d", name, n), 32'(obs), 32'(exp_vec(n)));
         if (oRdEn) reads++;
         iStart = (n == pulse_a) || (n == pulse_b);
         if (n == drop_n) iContinuous = 1'b0;
         if (n == rst_n) begin
            iRst = 1'b1;
            return;
         end
      end
   endtask

   task automatic idle_check(input string name, input int cycles, input int addr);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_eq($sformatf("%s.%0d", name, i), 32'(obs), {15'd0, 17'(addr)} << 8);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with a simultaneous start request: reset must win.
      iRst = 1'b1;
      iStart = 1'b1;
      iContinuous = 1'b0;
      idle_check("reset", 3, 0);
      iRst = 1'b0;
      iStart = 1'b0;
      idle_check("post_reset", 3, 0);

      // Single frame.
      iStart = 1'b1;
      run_frame("single", -1, -1, -1, -1, rd_a);
      check_eq("single.reads", 32'(rd_a), 32'(NPIX));
      idle_check("single.idle", 4, NPIX - 1);

      // Start pulses during ACTIVE and VFP are ignored.
      iStart = 1'b1;
      run_frame("ignstart", 24, 47, -1, -1, rd_a);
      check_eq("ignstart.reads", 32'(rd_a), 32'(NPIX));
      idle_check("ignstart.idle", 20, NPIX - 1);

      // Three back-to-back frames; continuous dropped during the third.
      iContinuous = 1'b1;
      iStart = 1'b1;
      run_frame("cont0", -1, -1, -1, -1, rd_a);
      run_frame("cont1", -1, -1, -1, -1, rd_b);
      run_frame("cont2", -1, -1, 10, -1, rd_c);
      rd_tot = rd_a + rd_b + rd_c;
      check_eq("cont.reads", 32'(rd_tot), 32'(3 * NPIX));
      idle_check("cont.idle", 4, NPIX - 1);

      // Reset while byte 3 of line 1 is on the bus, then a clean frame.
      iStart = 1'b1;
      run_frame("rstmid", -1, -1, -1, 36, rd_a);
      @(negedge clk);
      check_eq("rstmid.zero", 32'(obs), 32'd0);
      iRst = 1'b0;
      idle_check("rstmid.idle", 2, 0);
      iStart = 1'b1;
      run_frame("after_rst", -1, -1, -1, -1, rd_a);
      check_eq("after_rst.reads", 32'(rd_a), 32'(NPIX));
      idle_check("after_rst.idle", 3, NPIX - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
